// File: rtl/gb_pkg.sv
// ---------------------------------------------------------------------------
// gb_pkg
// Definitions shared by the Game Boy timer block:
//   - CPU-bus register offsets of the timer (0xFF04..0xFF07 -> 0..3)
//   - timer overflow state encoding
//   - TAC clock-select to system-counter bit mapping
// ---------------------------------------------------------------------------
package gb_pkg;

   localparam logic [1:0] TIMER_DIV  = 2'd0;
   localparam logic [1:0] TIMER_TIMA = 2'd1;
   localparam logic [1:0] TIMER_TMA  = 2'd2;
   localparam logic [1:0] TIMER_TAC  = 2'd3;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      OVF    = 2'd1,
      RELOAD = 2'd2
   } timer_state_t;

   // Counter bit watched by the TIMA tick for each TAC clock select.
   function automatic logic [3:0] tac_sel_bit(input logic [1:0] sel);
      logic [3:0] bit_idx;
      case (sel)
         2'b00:   bit_idx = 4'd9;   // 4096 Hz
         2'b01:   bit_idx = 4'd3;   // 262144 Hz
         2'b10:   bit_idx = 4'd5;   // 65536 Hz
         default: bit_idx = 4'd7;   // 16384 Hz
      endcase
      return bit_idx;
   endfunction

endpackage

// File: rtl/gb_timer_edge.sv
// ---------------------------------------------------------------------------
// gb_timer_edge
// Tick mux and falling-edge detector for TIMA.
//   clk, rst   : system clock, asynchronous active-high reset
//   counter    : internal system counter
//   tac        : TAC[2:0] (enable + clock select)
//   tick_fall  : high while the selected tick has fallen since the last clk
// The tick is a pure function of register state, so writes to DIV or TAC
// that drop it produce a fall just like normal counting does.
// ---------------------------------------------------------------------------
module gb_timer_edge
   import gb_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DIV_W-1:0] counter,
   input  logic [2:0]       tac,
   output logic             tick_fall
);

   logic tick;
   logic tick_prev_reg;

   assign tick      = tac[2] & counter[tac_sel_bit(tac[1:0])];
   assign tick_fall = tick_prev_reg & ~tick;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_prev_reg <= 1'b0;
      end else begin
         tick_prev_reg <= tick;
      end
   end

endmodule

// File: rtl/gb_timer.sv
// ---------------------------------------------------------------------------
// gb_timer
// Game Boy DIV/TIMA/TMA/TAC timer, advanced by one-clk cpu_ce strobes.
//   clk, rst  : 100 MHz system clock, asynchronous active-high reset
//   cpu_ce    : one pulse per CPU T-cycle
//   addr      : 0=DIV 1=TIMA 2=TMA 3=TAC
//   wr_en     : register write strobe, wr_data is the write data
//   rd_data   : combinational read of the selected register
//   irq_timer : one-clk timer interrupt request (IF bit 2)
// ---------------------------------------------------------------------------
module gb_timer
   import gb_pkg::*;
#(
   parameter int DIV_W     = 16,
   parameter int OVF_DELAY = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_ce,
   input  logic [1:0] addr,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic [7:0] rd_data,
   output logic       irq_timer
);

   localparam int CNT_W = $clog2(OVF_DELAY + 1);

   logic [DIV_W-1:0] div_cnt_reg;
   logic [7:0]       tima_reg;
   logic [7:0]       tma_reg;
   logic [2:0]       tac_reg;
   timer_state_t     state_reg;
   logic [CNT_W-1:0] ovf_cnt_reg;
   logic             irq_reg;

   logic wr_div, wr_tima, wr_tma, wr_tac;
   logic tick_fall;

   assign wr_div  = wr_en && (addr == TIMER_DIV);
   assign wr_tima = wr_en && (addr == TIMER_TIMA);
   assign wr_tma  = wr_en && (addr == TIMER_TMA);
   assign wr_tac  = wr_en && (addr == TIMER_TAC);

   gb_timer_edge #(
      .DIV_W (DIV_W)
   ) u_edge (
      .clk       (clk),
      .rst       (rst),
      .counter   (div_cnt_reg),
      .tac       (tac_reg),
      .tick_fall (tick_fall)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div_cnt_reg <= '0;
         tima_reg    <= 8'h00;
         tma_reg     <= 8'h00;
         tac_reg     <= 3'b000;
         state_reg   <= RUN;
         ovf_cnt_reg <= '0;
         irq_reg     <= 1'b0;
      end else begin
         // A DIV write beats a coincident cpu_ce increment.
         if (wr_div) begin
            div_cnt_reg <= '0;
         end else if (cpu_ce) begin
            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
         end

         if (wr_tma) tma_reg <= wr_data;
         if (wr_tac) tac_reg <= wr_data[2:0];

         irq_reg <= 1'b0;

         case (state_reg)
            RUN: begin
               if (wr_tima) begin
                  tima_reg <= wr_data;
               end else if (tick_fall) begin
                  if (tima_reg == 8'hFF) begin
                     tima_reg    <= 8'h00;
                     state_reg   <= OVF;
                     ovf_cnt_reg <= '0;
                  end else begin
                     tima_reg <= tima_reg + 8'd1;
                  end
               end
            end
            OVF: begin
               // TIMA sits at 0x00; a CPU write here aborts the pending reload.
               if (wr_tima) begin
                  tima_reg  <= wr_data;
                  state_reg <= RUN;
               end else if (cpu_ce) begin
                  if (ovf_cnt_reg == CNT_W'(OVF_DELAY - 1)) begin
                     state_reg <= RELOAD;
                  end else begin
                     ovf_cnt_reg <= ovf_cnt_reg + CNT_W'(1);
                  end
               end
            end
            RELOAD: begin
               // A TMA write in this cycle forwards straight into TIMA;
               // TIMA writes are dropped.
               tima_reg  <= wr_tma ? wr_data : tma_reg;
               irq_reg   <= 1'b1;
               state_reg <= RUN;
            end
            default: begin
               state_reg <= RUN;
            end
         endcase
      end
   end

   always_comb begin
      rd_data = 8'h00;
      case (addr)
         TIMER_DIV:  rd_data = div_cnt_reg[DIV_W-1 -: 8];
         TIMER_TIMA: rd_data = tima_reg;
         TIMER_TMA:  rd_data = tma_reg;
         default:    rd_data = {5'b11111, tac_reg};
      endcase
   end

   assign irq_timer = irq_reg;

endmodule

// File: tb/tb_gb_timer.sv
// ---------------------------------------------------------------------------
// tb_gb_timer
// Directed self-checking bench for gb_timer. cpu_ce pulses are one clk wide
// followed by three idle clks, so every TIMA update settles before the next
// pulse. Inputs change and outputs are sampled 1 ns after the rising edge.
// ---------------------------------------------------------------------------
module tb_gb_timer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cpu_ce = 1'b0;
   logic [1:0] addr = 2'd0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic [7:0] rd_data;
   logic       irq_timer;

   int n_checks = 0;
   int n_fail   = 0;
   int irq_cnt  = 0;
   int irq_base = 0;

   gb_timer #(
      .DIV_W     (16),
      .OVF_DELAY (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_ce    (cpu_ce),
      .addr      (addr),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .rd_data   (rd_data),
      .irq_timer (irq_timer)
   );

   always #5 clk = ~clk;

   // Counts clks during which the interrupt request is high.
   always @(negedge clk) begin
      if (irq_timer) irq_cnt = irq_cnt + 1;
   end

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
      $display("check %-14s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
      addr = a;
      #1;
      check(tag, rd_data, exp);
   endtask

   task automatic pulse(input int n);
      repeat (n) begin
         cpu_ce = 1'b1;
         @(posedge clk); #1;
         cpu_ce = 1'b0;
         repeat (3) @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      addr    = a;
      wr_data = d;
      wr_en   = 1'b1;
      @(posedge clk); #1;
      wr_en   = 1'b0;
   endtask

   initial begin
      // ---- reset values ----
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      check_reg("rst_div",  2'd0, 8'h00);
      check_reg("rst_tima", 2'd1, 8'h00);
      check_reg("rst_tma",  2'd2, 8'h00);
      check_reg("rst_tac",  2'd3, 8'hF8);
      check("rst_irq", {7'b0, irq_timer}, 8'h00);

      // ---- 1024 pulses, timer disabled ----
      pulse(1024);
      check_reg("div_1024",  2'd0, 8'h04);
      check_reg("tima_1024", 2'd1, 8'h00);
      check("irq_1024", 8'(irq_cnt), 8'd0);

      // ---- normal overflow and reload ----
      wr(2'd0, 8'h00);          // counter 0, TAC still 0
      wr(2'd3, 8'h05);
      wr(2'd1, 8'hFE);
      wr(2'd2, 8'h80);
      irq_base = irq_cnt;
      pulse(16);
      check_reg("tima_16", 2'd1, 8'hFF);
      pulse(16);
      check_reg("tima_32", 2'd1, 8'h00);
      pulse(3);
      check_reg("tima_ovf3", 2'd1, 8'h00);
      check("irq_ovf3", 8'(irq_cnt - irq_base), 8'd0);
      pulse(1);
      check_reg("tima_reload", 2'd1, 8'h80);
      check("irq_once", 8'(irq_cnt - irq_base), 8'd1);

      // ---- TIMA write during OVF cancels reload ----
      wr(2'd0, 8'h00);
      wr(2'd1, 8'hFE);
      irq_base = irq_cnt;
      pulse(32);
      pulse(2);
      wr(2'd1, 8'h33);
      pulse(4);
      repeat (2) @(posedge clk);
      #1;
      check_reg("tima_cancel", 2'd1, 8'h33);
      check("irq_cancel", 8'(irq_cnt - irq_base), 8'd0);

      // ---- TMA write during RELOAD lands in TIMA ----
      wr(2'd0, 8'h00);
      wr(2'd1, 8'hFE);
      irq_base = irq_cnt;
      pulse(32);
      pulse(3);
      cpu_ce = 1'b1;            // 4th OVF pulse: state becomes RELOAD
      @(posedge clk); #1;
      cpu_ce  = 1'b0;
      addr    = 2'd2;
      wr_data = 8'h44;
      wr_en   = 1'b1;
      @(posedge clk); #1;
      wr_en   = 1'b0;
      check("irq_reload", {7'b0, irq_timer}, 8'h01);
      check_reg("tima_tmawr", 2'd1, 8'h44);
      check_reg("tma_tmawr",  2'd2, 8'h44);
      @(posedge clk); #1;
      check("irq_drop", {7'b0, irq_timer}, 8'h00);
      check("irq_tmawr", 8'(irq_cnt - irq_base), 8'd1);

      // ---- write-induced glitch increments ----
      wr(2'd0, 8'h00);
      wr(2'd1, 8'h10);
      pulse(8);                 // counter 0x0008, tick high
      check_reg("tima_pre", 2'd1, 8'h10);
      wr(2'd0, 8'hA5);          // DIV write drops bit 3
      @(posedge clk); #1;
      check_reg("tima_divgl", 2'd1, 8'h11);
      check_reg("div_clr",    2'd0, 8'h00);
      pulse(8);
      wr(2'd3, 8'h00);          // disabling drops the tick
      @(posedge clk); #1;
      check_reg("tima_tacgl", 2'd1, 8'h12);
      wr(2'd3, 8'h04);          // bit 9 selected, low
      wr(2'd0, 8'h00);
      @(posedge clk); #1;
      check_reg("tima_nogl", 2'd1, 8'h12);

      // ---- reset in the middle of OVF ----
      wr(2'd3, 8'h05);
      wr(2'd1, 8'hFF);
      irq_base = irq_cnt;
      pulse(16);
      pulse(2);
      rst = 1'b1;
      #1;
      check_reg("rst_ovf_tima", 2'd1, 8'h00);
      check_reg("rst_ovf_tma",  2'd2, 8'h00);
      check_reg("rst_ovf_tac",  2'd3, 8'hF8);
      check_reg("rst_ovf_div",  2'd0, 8'h00);
      repeat (6) @(posedge clk);
      #1 rst = 1'b0;
      pulse(8);
      check("irq_rst", 8'(irq_cnt - irq_base), 8'd0);
      wr(2'd3, 8'h05);
      pulse(16);
      check_reg("tima_after", 2'd1, 8'h01);
      check_reg("div_after",  2'd0, 8'h00);
      check("irq_after", 8'(irq_cnt - irq_base), 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gb_timer.md
# gb_timer

Game Boy DIV/TIMA/TMA/TAC timer peripheral, the consumer end of the CPU clock divider. It runs entirely on the 100 MHz system clock and advances only on single-cycle `cpu_ce` strobes, one per CPU T-cycle. It exposes the four timer registers (0xFF04–0xFF07) to the CPU bus and raises the timer interrupt request toward the IF/interrupt controller.

## Interface
- `DIV_W`, 16: width of the internal system counter. DIV is the upper byte.
- `OVF_DELAY`, 4: T-cycles between TIMA overflow and the TMA reload/IRQ.
- `clk` input 1: system clock (100 MHz). The block is single-clock and has no other clock input.
- `rst` input 1: asynchronous, active-high reset.
- `cpu_ce` input 1: one-`clk` pulse per CPU T-cycle. All counting is qualified by it.
- `addr` input 2: register select. 0=DIV, 1=TIMA, 2=TMA, 3=TAC.
- `wr_en` input 1: write strobe, honoured on any `clk` edge.
- `wr_data` input 8: write data.
- `rd_data` output 8: combinational read of the selected register.
- `irq_timer` output 1: one-`clk` pulse requesting IF bit 2.

## Operation
- Reset values:
  - system counter = 0, TIMA = 0, TMA = 0, TAC = 0.
  - state = RUN, `irq_timer` = 0.
  - `rd_data` follows the register values.
- The system counter increments by 1 on each `clk` where `cpu_ce`=1, wrapping 0xFFFF→0x0000.
- DIV reads as counter[15:8].
- A write to DIV, with any data, clears the whole counter.
- TAC uses bits [2:0] only:
  - Bit 2 is the enable.
  - Bits [1:0] select the counter bit: 00→bit 9 (4096 Hz), 01→bit 3, 10→bit 5, 11→bit 7.
  - TAC reads as {5'b11111, TAC[2:0]}.
- Tick signal = TAC[2] & counter[sel]. TIMA increments on every 1→0 transition of the tick signal, evaluated every `clk`. The DMG glitches are therefore reproduced:
  - A DIV write, a TAC disable or a select change can each produce an extra increment.
- State machine:
  - **RUN:** on a tick while TIMA = 0xFF, TIMA becomes 0x00 and the state goes to OVF.
  - **OVF:** TIMA reads 0x00. A counter counts `cpu_ce` pulses. After `OVF_DELAY` pulses the state goes to RELOAD.
  - **RELOAD:** lasts exactly one `clk`. TIMA ← TMA, `irq_timer` = 1, then the state returns to RUN.
- Boundary rules:
  - A TIMA write in OVF loads `wr_data`, cancels the reload and IRQ, and returns the state to RUN.
  - A TIMA write in RELOAD is ignored. TMA wins.
  - A TMA write in RELOAD: the new `wr_data` is what lands in TIMA.
  - A TMA write in RUN or OVF only updates TMA.
  - A tick in OVF or RELOAD does not increment TIMA.
  - A write coinciding with `cpu_ce` takes priority over the increment for that register. For example, a DIV write plus `cpu_ce` leaves the counter at 0.
  - Reset asserted mid-OVF returns all state to reset values with no IRQ.

## Timing
- Counter and DIV update on the same edge as the `cpu_ce` pulse.
- TIMA increment: one `clk` after the falling tick edge is registered, i.e. visible on the edge following the counter update.
- Overflow to IRQ: `OVF_DELAY` `cpu_ce` pulses plus 1 `clk`. `irq_timer` is high for exactly one `clk`, coincident with TIMA = TMA becoming visible.
- `rd_data` is combinational from registers, with no added read latency.
- With `cpu_ce` held low, nothing changes except register writes and write-induced ticks.

## Structure
- Shared package `gb_pkg`:
  - register offsets: `TIMER_DIV`, `TIMER_TIMA`, `TIMER_TMA`, `TIMER_TAC`.
  - state encoding: RUN, OVF, RELOAD.
  - the TAC select-to-bit mapping function.
- One natural sub-module: `gb_timer_edge`, the tick mux and falling-edge detector (registered previous tick, output pulse).
- Everything else stays in `gb_timer`.

## Test plan
- Reset, then 1024 `cpu_ce` pulses with TAC=0 -> DIV=0x04, TIMA=0x00, no IRQ.
- TAC=0x05 (enable, bit 3), TIMA=0xFE, TMA=0x80, then 32 `cpu_ce` pulses -> TIMA 0xFF at 16, 0x00 at 32; 4 more pulses -> TIMA=0x80 and a single 1-`clk` `irq_timer` pulse.
- Same overflow, but write TIMA=0x33 two pulses into OVF -> TIMA=0x33, no IRQ, no reload.
- Same overflow, but write TMA=0x44 in the RELOAD cycle -> TIMA=0x44, IRQ fires once.
- TAC=0x05, counter=0x0008 (bit 3 set), then write DIV -> counter 0, TIMA +1 (glitch increment); repeat with TAC=0x04 -> no increment.
- Assert `rst` during OVF -> all registers 0, `irq_timer` stays 0, and after release the block counts normally from 0.
